seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
- Word-level controller for the serial Moore sequence detector.
- Accepts a parallel word over a valid/ready handshake and serializes it MSB-first into an internal Moore detector core, which matches against a programmable pattern.
- Counts matches and returns a per-word result over a second valid/ready handshake.
- Sits between a parallel producer and a pattern-statistics consumer, and replaces hand-driven serial stimulus of the detector.

Parameters:
- DATA_W, 8: input word width; number of serial bits per word.
- PAT_W, 4: pattern length in bits; 2..DATA_W.
- CNT_W, 4: match-counter width; count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- cfg_pat  input  PAT_W  pattern to detect; cfg_pat[PAT_W-1] is the first bit in time.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = detector history cleared after each match.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller can accept a word.
- in_data  input  DATA_W  word to scan; MSB is serialized first.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CNT_W  number of matches in the word.
- out_hit  output  1  out_count != 0.
- ser_bit  output  1  bit currently presented to the detector; 0 outside SHIFT.
- det_y  output  1  registered Moore detector output.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; out_count=0; out_hit=0; ser_bit=0; det_y=0; detector history and fill count cleared.
- FSM states: IDLE, SHIFT, DRAIN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch in_data into the shift register, and cfg_pat/cfg_overlap into shadow registers;
    - clear bit_idx, match count and detector history;
    - go to SHIFT.
  - SHIFT: in_ready=0; ser_bit=shreg MSB. Each edge:
    - detector consumes ser_bit;
    - shreg shifts left;
    - bit_idx increments.
    - After DATA_W edges, go to DRAIN.
  - DRAIN: one cycle; ser_bit=0. Captures det_y for the final bit. Go to DONE.
  - DONE: out_valid=1; out_count and out_hit held stable. On out_ready go to IDLE. out_valid is held indefinitely while out_ready=0.
- Detector core (Moore):
  - hist (PAT_W bits) shifts in ser_bit.
  - fill counter saturates at PAT_W.
  - det_y registered: equals 1 on the edge after the consuming edge whenever fill==PAT_W and {hist, new bit} matches the pattern.
  - cfg_overlap=0: on a match, hist and fill are cleared on the same edge.
- Counting: count increments on every edge where det_y=1 in SHIFT or DRAIN. It saturates and does not wrap.
- Latency: out_valid rises exactly DATA_W+1 edges after the accepting edge. Minimum word period is DATA_W+3 cycles with out_ready held high.
- Configuration: cfg_pat and cfg_overlap changes during SHIFT/DRAIN/DONE have no effect on the current word.
- Word isolation: detector history never spans words.
- Reset mid-operation: word is discarded, no result is produced, and the controller returns to IDLE.

Optional Feature:
- SEQ_CTRL_FIRSTPOS_EN defined:
  - adds output out_first_pos [$clog2(DATA_W)-1:0], the bit_idx (0 = MSB) of the last bit of the first match;
  - value is 0 when out_hit=0;
  - reset value 0; held with out_count.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg:
  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DRAIN=2'd2, DONE=2'd3);
  - default widths.
- Sub-module seq_det_core: programmable Moore detector (hist, fill, det_y, overlap control), instantiated once.

Test Plan:
- Pattern 4'b1101, overlap=1, in_data=8'b11011011 -> out_count=2, out_hit=1; out_valid exactly 9 edges after the accept.
- Same pattern and data, overlap=0 -> out_count=1.
- Pattern 4'b1111, in_data=8'hFF -> overlap=1 gives count 5; overlap=0 gives count 2. With SEQ_CTRL_FIRSTPOS_EN, out_first_pos=3 in both cases.
- Pattern 4'b1101, in_data=8'h00 -> out_count=0, out_hit=0; cfg_pat changed mid-SHIFT has no effect on the result.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_count stable, in_ready=0; second word is accepted only after the out handshake.
- rst=0 pulse in SHIFT at bit_idx=4 -> all outputs take reset values immediately, no result is produced; the next word is processed correctly.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding and default widths for the sequence detector controller
//
// Purpose : controller FSM state encoding and default parameter values.
// Ports   : none (package).
package seq_det_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PAT_W_DEF  = 4;
  localparam int CNT_W_DEF  = 4;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_SHIFT = 2'd1;
  localparam logic [1:0] ENC_DRAIN = 2'd2;
  localparam logic [1:0] ENC_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    SHIFT = ENC_SHIFT,
    DRAIN = ENC_DRAIN,
    DONE  = ENC_DONE
  } state_t;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// rtl/seq_det_ctrl_if.sv - word-in / result-out handshake bundle for seq_det_ctrl
//
// Purpose : groups the input word handshake and the result handshake.
// Signals : in_valid/in_ready/in_data   producer -> controller word
//           out_valid/out_ready          controller -> consumer result handshake
//           out_count/out_hit            per-word match count and nonzero flag
// Modports: master (producer/consumer side), slave (controller side).
interface seq_det_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              out_hit;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_hit
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_hit
  );
endinterface

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - programmable serial Moore sequence detector
//
// Purpose : matches the serial bit stream against a PAT_W-bit pattern.
// Ports   : clk, rst (async, active-low)
//           clr_i      clears history, fill count and det_y
//           en_i       consume bit_i on this edge
//           bit_i      serial input bit
//           pat_i      pattern, pat_i[PAT_W-1] is the oldest bit
//           overlap_i  1 = overlapping matches, 0 = history cleared on match
//           det_y_o    registered match flag, high the cycle after the matching bit
module seq_det_core #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic             overlap_i,
  output logic             det_y_o
);

  // Only the previous PAT_W-1 bits need storing: the incoming bit completes the window.
  localparam int HIST_W = PAT_W - 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic              det_y_q, det_y_d;
  logic [PAT_W-1:0]  window;
  logic              match;

  always_comb begin
    window   = {hist_q, bit_i};
    fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match    = en_i && (fill_inc == FILL_FULL) && (window == pat_i);

    hist_d  = hist_q;
    fill_d  = fill_q;
    det_y_d = 1'b0;

    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en_i) begin
      det_y_d = match;
      if (match && !overlap_i) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[HIST_W-1:0];
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      det_y_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      det_y_q <= det_y_d;
    end
  end

  assign det_y_o = det_y_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - word-level controller serializing words into the Moore sequence detector
//
// Purpose : accepts a word, shifts it MSB-first into seq_det_core, counts matches
//           and returns the count over a result handshake.
// Ports   : clk, rst (async, active-low)
//           cfg_pat, cfg_overlap  pattern / overlap mode, sampled on word accept
//           bus (slave)           in_valid/in_ready/in_data, out_valid/out_ready/out_count/out_hit
//           ser_bit               bit presented to the detector (0 outside SHIFT)
//           det_y                 registered detector output
//           out_first_pos         only with SEQ_CTRL_FIRSTPOS_EN: index of the last bit of the first match
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PAT_W  = PAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic             cfg_overlap,
  seq_det_ctrl_if.slave    bus,
  output logic             ser_bit,
  output logic             det_y
`ifdef SEQ_CTRL_FIRSTPOS_EN
  ,
  output logic [$clog2(DATA_W)-1:0] out_first_pos
`endif
);

  localparam int POS_W = $clog2(DATA_W);
  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [POS_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic              core_clr, core_en;
  logic              in_ready_c, out_valid_c;
`ifdef SEQ_CTRL_FIRSTPOS_EN
  logic [POS_W-1:0]  first_pos_q, first_pos_d;
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    ovl_d       = ovl_q;
    core_clr    = 1'b0;
    core_en     = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
`ifdef SEQ_CTRL_FIRSTPOS_EN
    first_pos_d = first_pos_q;
`endif

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          shreg_d   = bus.in_data;
          pat_d     = cfg_pat;
          ovl_d     = cfg_overlap;
          bit_idx_d = '0;
          cnt_d     = '0;
          core_clr  = 1'b1;
`ifdef SEQ_CTRL_FIRSTPOS_EN
          first_pos_d = '0;
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        core_en   = 1'b1;
        shreg_d   = shreg_q << 1;
        bit_idx_d = bit_idx_q + POS_W'(1);
        if (bit_idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // det_y lags the consumed bit by one edge, so the final bit's match is
    // only visible during DRAIN.
    if ((state_q == SHIFT || state_q == DRAIN) && det_y) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_CTRL_FIRSTPOS_EN
      // bit_idx has already advanced past the matching bit; in DRAIN it was the last one.
      if (cnt_q == '0)
        first_pos_d = (state_q == DRAIN) ? LAST_IDX : bit_idx_q - POS_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      pat_q     <= '0;
      ovl_q     <= 1'b0;
`ifdef SEQ_CTRL_FIRSTPOS_EN
      first_pos_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      ovl_q     <= ovl_d;
`ifdef SEQ_CTRL_FIRSTPOS_EN
      first_pos_q <= first_pos_d;
`endif
    end
  end

  assign ser_bit       = (state_q == SHIFT) ? shreg_q[DATA_W-1] : 1'b0;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_count = cnt_q;
  assign bus.out_hit   = (cnt_q != '0);
`ifdef SEQ_CTRL_FIRSTPOS_EN
  assign out_first_pos = first_pos_q;
`endif

  seq_det_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (core_clr),
    .en_i      (core_en),
    .bit_i     (ser_bit),
    .pat_i     (pat_q),
    .overlap_i (ovl_q),
    .det_y_o   (det_y)
  );

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - scoreboard testbench for seq_det_ctrl
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cfg_pat = 4'd0;
  logic       cfg_overlap = 1'b0;
  logic       ser_bit;
  logic       det_y;
`ifdef SEQ_CTRL_FIRSTPOS_EN
  logic [2:0] out_first_pos;
`endif

  seq_det_ctrl_if #(.DATA_W(8), .CNT_W(4)) bus ();

  seq_det_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_pat     (cfg_pat),
    .cfg_overlap (cfg_overlap),
    .bus         (bus),
    .ser_bit     (ser_bit),
    .det_y       (det_y)
`ifdef SEQ_CTRL_FIRSTPOS_EN
    ,
    .out_first_pos (out_first_pos)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int fp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Independent reference: slide a 4-bit window over the word, MSB first.
  function automatic exp_t model(logic [7:0] d, logic [3:0] p, logic ovl);
    exp_t       e;
    logic [3:0] w;
    int         n;
    e.cnt = 0; e.fp = 0; w = '0; n = 0;
    for (int i = 0; i < 8; i++) begin
      w = {w[2:0], d[7-i]};
      n = (n < 4) ? n + 1 : 4;
      if (n == 4 && w == p) begin
        if (e.cnt == 0) e.fp = i;
        if (e.cnt < 15) e.cnt++;
        if (!ovl) begin n = 0; w = '0; end
      end
    end
    return e;
  endfunction

  // Presents a word once the DUT is ready; returns at accept edge + 1.
  task automatic drive_word(input logic [7:0] d, input logic [3:0] p, input logic ovl);
    int waitc = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: in_ready=%b want 1", bus.in_ready);
    end
    bus.in_data  = d;
    cfg_pat      = p;
    cfg_overlap  = ovl;
    bus.in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(d, p, ovl));
    #1 bus.in_valid = 1'b0;
  endtask

  // Waits for the result, checks latency and contents, then completes the handshake.
  task automatic get_result(input string name, input int want_cnt, input int want_fp, input int pre);
    int   edges = pre;
    exp_t e;
    e.cnt = -1; e.fp = -1;
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    total++;
    if (edges != 9) begin
      bad++;
      $display("FAIL %s_latency: got %0d edges want 9", name, edges);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_scoreboard: got empty queue want 1 entry", name);
    end else begin
      e = sb.pop_front();
    end
    total++;
    if (int'(bus.out_count) !== e.cnt) begin
      bad++;
      $display("FAIL %s_count_sb: got %0d want %0d", name, bus.out_count, e.cnt);
    end
    total++;
    if (int'(bus.out_count) !== want_cnt) begin
      bad++;
      $display("FAIL %s_count: got %0d want %0d", name, bus.out_count, want_cnt);
    end
    total++;
    if (bus.out_hit !== (want_cnt != 0)) begin
      bad++;
      $display("FAIL %s_hit: got %b want %b", name, bus.out_hit, (want_cnt != 0));
    end
`ifdef SEQ_CTRL_FIRSTPOS_EN
    total++;
    if (int'(out_first_pos) !== want_fp || int'(out_first_pos) !== e.fp) begin
      bad++;
      $display("FAIL %s_first_pos: got %0d want %0d", name, out_first_pos, want_fp);
    end
`endif
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_count, bus.out_hit, ser_bit, det_y} !== 9'b1_0_0000_0_0_0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 100000000",
               {bus.in_ready, bus.out_valid, bus.out_count, bus.out_hit, ser_bit, det_y});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_overlap();
    drive_word(8'b11011011, 4'b1101, 1'b1);
    get_result("ovl_1101", 2, 3, 0);
    drive_word(8'b11011011, 4'b1101, 1'b0);
    get_result("novl_1101", 1, 3, 0);
  endtask

  task automatic test_all_ones();
    drive_word(8'hFF, 4'b1111, 1'b1);
    get_result("ones_ovl", 5, 3, 0);
    drive_word(8'hFF, 4'b1111, 1'b0);
    get_result("ones_novl", 2, 3, 0);
  endtask

  task automatic test_zero_cfg_change();
    drive_word(8'h00, 4'b1101, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    cfg_pat     = 4'b0000;
    cfg_overlap = 1'b0;
    get_result("zero_cfgchg", 0, 0, 3);
  endtask

  task automatic test_backpressure();
    int   edges = 0;
    exp_t e;
    e.cnt = -1; e.fp = -1;
    drive_word(8'b01101101, 4'b1101, 1'b1);
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    total++;
    if (edges != 9) begin
      bad++;
      $display("FAIL bp_latency: got %0d edges want 9", edges);
    end
    bus.in_data  = 8'hFF;
    cfg_pat      = 4'b1111;
    cfg_overlap  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.out_count, bus.in_ready} !== 6'b1_0010_0) begin
        bad++;
        $display("FAIL bp_hold%0d: got valid/count/in_ready=%b want 100100", i,
                 {bus.out_valid, bus.out_count, bus.in_ready});
      end
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL bp_scoreboard: got empty queue want 1 entry");
    end else begin
      e = sb.pop_front();
    end
    total++;
    if (int'(bus.out_count) !== e.cnt) begin
      bad++;
      $display("FAIL bp_count_sb: got %0d want %0d", bus.out_count, e.cnt);
    end
`ifdef SEQ_CTRL_FIRSTPOS_EN
    total++;
    if (int'(out_first_pos) !== 4) begin
      bad++;
      $display("FAIL bp_first_pos: got %0d want 4", out_first_pos);
    end
`endif
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    sb.push_back(model(8'hFF, 4'b1111, 1'b1));
    #1 bus.in_valid = 1'b0;
    get_result("bp_second", 5, 3, 0);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    drive_word(8'hFF, 4'b1111, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({ser_bit, det_y} !== 2'b11) begin
      bad++;
      $display("FAIL midrst_pre: got ser_bit/det_y=%b want 11", {ser_bit, det_y});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_count, bus.out_hit, ser_bit, det_y} !== 9'b1_0_0000_0_0_0) begin
      bad++;
      $display("FAIL midrst_outputs: got %b want 100000000",
               {bus.in_ready, bus.out_valid, bus.out_count, bus.out_hit, ser_bit, det_y});
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen);
    end
    drive_word(8'b01101101, 4'b1101, 1'b1);
    get_result("post_rst", 2, 4, 0);
  endtask

  task automatic test_back_to_back();
    int         sent = 0, got = 0, cyc = 0, last_acc = -1;
    logic       take_in, take_out;
    logic [7:0] cur_d;
    logic       cur_o;
    exp_t       e;
    cur_d = 8'($urandom);
    cur_o = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_data  = cur_d;
    cfg_pat      = 4'b1011;
    cfg_overlap  = cur_o;
    bus.in_valid = 1'b1;
    while (got < 4 && cyc < 100) begin
      take_in  = bus.in_valid && bus.in_ready;
      take_out = bus.out_valid && bus.out_ready;
      if (take_out) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL b2b_scoreboard: got empty queue want 1 entry");
        end else begin
          e = sb.pop_front();
          total++;
          if (int'(bus.out_count) !== e.cnt || bus.out_hit !== (e.cnt != 0)) begin
            bad++;
            $display("FAIL b2b_count%0d: got %0d/%b want %0d", got, bus.out_count, bus.out_hit, e.cnt);
          end
        end
        got++;
      end
      @(posedge clk);
      cyc++;
      if (take_in) begin
        sb.push_back(model(cur_d, 4'b1011, cur_o));
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != 11) begin
            bad++;
            $display("FAIL b2b_period: got %0d want 11", cyc - last_acc);
          end
        end
        last_acc = cyc;
        sent++;
        #1;
        if (sent < 4) begin
          cur_d        = 8'($urandom);
          cur_o        = ~cur_o;
          bus.in_data  = cur_d;
          cfg_overlap  = cur_o;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    total++;
    if (got != 4) begin
      bad++;
      $display("FAIL b2b_results: got %0d want 4", got);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_overlap();
    test_all_ones();
    test_zero_cfg_change();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
